pipe_skid_stage: RTL

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage_pkg.sv | 12 +
 rtl/pipe_skid_stage_if.sv | 26 ++
 rtl/pipe_skid_entry.sv | 24 ++
 rtl/pipe_skid_stage.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline definitions: stage occupancy encoding and the RV32 NOP bubble payload.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } pipe_state_e;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle for pipe_skid_stage: upstream offer, downstream presentation, flush, occupancy.
interface pipe_skid_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [1:0]        occupancy_o;

  modport master (
    output flush_i, in_valid_i, in_data_i, in_ctrl_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_ctrl_o, occupancy_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_data_i, in_ctrl_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_ctrl_o, occupancy_o
  );
endinterface

// File: rtl/pipe_skid_entry.sv
// One held pipeline entry ({ctrl, data}): load on en, return to the bubble value on clr or reset.
module pipe_skid_entry #(
  parameter int unsigned      WIDTH   = 40,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage with optional skid buffer. Define PIPE_SKID_STAGE_SKID_EN for the two-entry,
// registered-ready variant; otherwise a single entry with combinational ready.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       CTRL_W   = 8,
  parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(RV32_NOP)
) (
  input logic         clk,
  input logic         rst_n,
  pipe_skid_stage_if.slave bus
);

  localparam int unsigned W = CTRL_W + DATA_W;
  localparam logic [W-1:0] NOP_ENTRY = {{CTRL_W{1'b0}}, NOP_DATA};

  pipe_state_e state_q, state_d;
  logic in_ready, out_valid, in_fire, out_fire;
  logic main_en, main_clr;
  logic [W-1:0] in_entry, main_d, main_q;

  assign in_entry  = {bus.in_ctrl_i, bus.in_data_i};
  assign out_valid = (state_q != StEmpty);
  assign in_fire   = bus.in_valid_i & in_ready & ~bus.flush_i;
  assign out_fire  = out_valid & bus.out_ready_i;

`ifdef PIPE_SKID_STAGE_SKID_EN
  logic skid_en, skid_clr, main_from_skid, ready_q;
  logic [W-1:0] skid_q;

  assign main_d = main_from_skid ? skid_q : in_entry;

  // Ready is registered from the next state so it never depends on out_ready_i this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_d != StFull);
    end
  end
  assign in_ready = ready_q;

  pipe_skid_entry #(
    .WIDTH  (W),
    .RST_VAL(NOP_ENTRY)
  ) u_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (skid_en),
    .clr  (skid_clr),
    .d    (in_entry),
    .q    (skid_q)
  );
`else
  logic alive_q;

  assign main_d = in_entry;

  // Holds ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
    end
  end
  assign in_ready = alive_q & (~out_valid | bus.out_ready_i);
`endif

  always_comb begin
    state_d  = state_q;
    main_en  = 1'b0;
    main_clr = 1'b0;
`ifdef PIPE_SKID_STAGE_SKID_EN
    skid_en        = 1'b0;
    skid_clr       = 1'b0;
    main_from_skid = 1'b0;
`endif
    if (bus.flush_i) begin
      state_d  = StEmpty;
      main_clr = 1'b1;
`ifdef PIPE_SKID_STAGE_SKID_EN
      skid_clr = 1'b1;
`endif
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_en = 1'b1;
            state_d = StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
`ifdef PIPE_SKID_STAGE_SKID_EN
          end else if (in_fire) begin
            skid_en = 1'b1;
            state_d = StFull;
`endif
          end else if (out_fire) begin
            main_clr = 1'b1;
            state_d  = StEmpty;
          end
        end
`ifdef PIPE_SKID_STAGE_SKID_EN
        StFull: begin
          if (out_fire) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = StOne;
          end
        end
`endif
        default: begin
          state_d  = StEmpty;
          main_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_skid_entry #(
    .WIDTH  (W),
    .RST_VAL(NOP_ENTRY)
  ) u_main (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (main_en),
    .clr  (main_clr),
    .d    (main_d),
    .q    (main_q)
  );

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = main_q[DATA_W-1:0];
  assign bus.out_ctrl_o  = main_q[W-1:DATA_W];
  assign bus.occupancy_o = state_q;

endmodule
